// File: rtl/wb_dual_master_arbiter_if.sv
// wb_dual_master_arbiter_if: one Wishbone link; master modport drives the request side.
interface wb_dual_master_arbiter_if;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        ack, err;
    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// wb_dual_master_arbiter: shares one Wishbone port between instruction (m0) and data (m1)
// masters, data-first with a fairness streak limit and a hung-slave watchdog.
module wb_dual_master_arbiter #(
    parameter int FAIR_LIMIT = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    wb_dual_master_arbiter_if.slave         m0,
    wb_dual_master_arbiter_if.slave         m1,
    wb_dual_master_arbiter_if.master        s,
    output logic [1:0]                      grant,
    output logic                            timeout
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
    state_t      state;
    logic [3:0]  streak;
    logic [15:0] wdog;
    logic        own0, own1, arb, pick1, hung, expire;

    assign own0    = state == OWN0;
    assign own1    = state == OWN1;
    assign timeout = state == ABORT;
    assign s.cyc   = own0 ? m0.cyc   : own1 ? m1.cyc   : 1'b0;
    assign s.stb   = own0 ? m0.stb   : own1 ? m1.stb   : 1'b0;
    assign s.we    = own0 ? m0.we    : own1 ? m1.we    : 1'b0;
    assign s.sel   = own0 ? m0.sel   : own1 ? m1.sel   : 4'h0;
    assign s.adr   = own0 ? m0.adr   : own1 ? m1.adr   : 32'h0;
    assign s.dat_w = own0 ? m0.dat_w : own1 ? m1.dat_w : 32'h0;
    assign m0.ack  = own0 & s.ack;
    assign m1.ack  = own1 & s.ack;
    assign m0.err  = (own0 & s.err) | (timeout & grant[0]);
    assign m1.err  = (own1 & s.err) | (timeout & grant[1]);
    assign m0.dat_r = |grant ? s.dat_r : 32'h0;
    assign m1.dat_r = |grant ? s.dat_r : 32'h0;

    // Arbitrate from IDLE or at the edge where the owner lets go of cyc, so handover costs no cycle.
    assign arb    = state == IDLE || (own0 && !m0.cyc) || (own1 && !m1.cyc);
    assign pick1  = m1.cyc && !(m0.cyc && streak == 4'(FAIR_LIMIT));
    assign hung   = TIMEOUT != 0 && (own0 ? m0.stb : own1 & m1.stb) && !s.ack && !s.err;
    assign expire = hung && wdog == 16'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= 2'b00;
            streak <= 4'd0;
            wdog   <= 16'd0;
        end else if (state == ABORT) begin
            state <= IDLE;
            grant <= 2'b00;
            wdog  <= 16'd0;
        end else if (arb) begin
            wdog <= 16'd0;
            if (pick1) begin
                state <= OWN1;
                grant <= 2'b10;
                if (m0.cyc) streak <= streak + 4'd1;
            end else if (m0.cyc) begin
                state  <= OWN0;
                grant  <= 2'b01;
                streak <= 4'd0;
            end else begin
                state <= IDLE;
                grant <= 2'b00;
            end
        end else if (expire) begin
            state <= ABORT;
            wdog  <= 16'd0;
        end else begin
            wdog <= hung ? wdog + 16'd1 : 16'd0;
        end
    end
endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// tb_wb_dual_master_arbiter: directed bench; read data checked through per-master scoreboards.
module tb_wb_dual_master_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  grant;
    logic        timeout;
    int          vectors = 0;
    int          errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  exp_arb [9] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};

    wb_dual_master_arbiter_if m0();
    wb_dual_master_arbiter_if m1();
    wb_dual_master_arbiter_if s();

    wb_dual_master_arbiter #(.FAIR_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .s(s), .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (m0.ack) begin
            if (q0.size() == 0) check("m0 spurious ack", m0.ack, 1'b0);
            else check("m0 rdata", m0.dat_r, q0.pop_front());
        end
        if (m1.ack) begin
            if (q1.size() == 0) check("m1 spurious ack", m1.ack, 1'b0);
            else check("m1 rdata", m1.dat_r, q1.pop_front());
        end
    end

    initial begin
        int n;
        {m0.cyc, m0.stb, m0.we, m0.sel, m0.adr, m0.dat_w} = '0;
        {m1.cyc, m1.stb, m1.we, m1.sel, m1.adr, m1.dat_w} = '0;
        {s.ack, s.err} = 2'b00;
        s.dat_r = 32'hA5A5_A5A5;
        #3;
        check("rst grant", grant, 2'b00);
        check("rst s_cyc", s.cyc, 1'b0);
        check("rst m0_data", m0.dat_r, 32'h0);
        check("rst timeout", timeout, 1'b0);
        tick;
        rst_n = 1'b1;

        // m0 alone
        tick;
        m0.cyc = 1'b1; m0.stb = 1'b1; m0.adr = 32'h100; m0.sel = 4'hF;
        @(negedge clk);
        check("t0 grant", grant, 2'b00);
        check("t0 s_cyc", s.cyc, 1'b0);
        tick;
        @(negedge clk);
        check("t1 grant", grant, 2'b01);
        check("t1 s_cyc", s.cyc, 1'b1);
        check("t1 s_adr", s.adr, 32'h100);
        tick;
        q0.push_back(32'hDEAD_BEEF);
        s.ack = 1'b1; s.dat_r = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t2 m0_ack", m0.ack, 1'b1);
        check("t2 m1_ack", m1.ack, 1'b0);
        tick;
        s.ack = 1'b0; m0.cyc = 1'b0; m0.stb = 1'b0;
        tick;
        @(negedge clk);
        check("m0 release", grant, 2'b00);

        // contention then handover
        tick;
        m0.cyc = 1'b1; m0.stb = 1'b1; m0.adr = 32'h300;
        m1.cyc = 1'b1; m1.stb = 1'b1; m1.we = 1'b1; m1.adr = 32'h200; m1.dat_w = 32'h1234;
        tick;
        @(negedge clk);
        check("contend grant", grant, 2'b10);
        check("contend s_adr", s.adr, 32'h200);
        check("contend s_we", s.we, 1'b1);
        check("contend s_dat", s.dat_w, 32'h1234);
        tick;
        q1.push_back(32'h1111_2222);
        s.ack = 1'b1; s.dat_r = 32'h1111_2222;
        @(negedge clk);
        check("contend m0_ack", m0.ack, 1'b0);
        tick;
        s.ack = 1'b0; m1.cyc = 1'b0; m1.stb = 1'b0; m1.we = 1'b0;
        @(negedge clk);
        check("m1 drop owner", grant, 2'b10);
        check("m1 drop s_cyc", s.cyc, 1'b0);
        tick;
        @(negedge clk);
        check("handover grant", grant, 2'b01);
        check("handover s_adr", s.adr, 32'h300);

        // m0 burst while m1 waits
        m1.cyc = 1'b1; m1.stb = 1'b1; m1.adr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            tick;
            q0.push_back(32'hB000_0000 + i);
            s.ack = 1'b1; s.dat_r = 32'hB000_0000 + i;
            @(negedge clk);
            check("burst grant", grant, 2'b01);
        end
        tick;
        s.ack = 1'b0; m0.cyc = 1'b0; m0.stb = 1'b0;
        @(negedge clk);
        check("burst end owner", grant, 2'b01);
        tick;
        @(negedge clk);
        check("after burst grant", grant, 2'b10);
        check("after burst s_adr", s.adr, 32'h400);
        tick;
        m1.cyc = 1'b0; m1.stb = 1'b0;
        tick;
        @(negedge clk);
        check("idle again", grant, 2'b00);

        // watchdog abort
        tick;
        m1.cyc = 1'b1; m1.stb = 1'b1;
        tick;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("wd stb", s.stb, 1'b1);
            check("wd no abort", timeout, 1'b0);
            tick;
        end
        @(negedge clk);
        check("abort s_cyc", s.cyc, 1'b0);
        check("abort m1_err", m1.err, 1'b1);
        check("abort m0_err", m0.err, 1'b0);
        check("abort timeout", timeout, 1'b1);
        check("abort grant", grant, 2'b10);
        m1.cyc = 1'b0; m1.stb = 1'b0;
        tick;
        @(negedge clk);
        check("post abort grant", grant, 2'b00);
        check("post abort timeout", timeout, 1'b0);

        // ack on the last permitted cycle beats the watchdog
        tick;
        m1.cyc = 1'b1; m1.stb = 1'b1;
        tick;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            tick;
        end
        q1.push_back(32'hCAFE_F00D);
        s.ack = 1'b1; s.dat_r = 32'hCAFE_F00D;
        @(negedge clk);
        tick;
        s.ack = 1'b0; m1.stb = 1'b0;
        @(negedge clk);
        check("late ack timeout", timeout, 1'b0);
        check("late ack grant", grant, 2'b10);
        check("late ack m1_err", m1.err, 1'b0);
        m1.cyc = 1'b0;
        tick;
        tick;
        @(negedge clk);
        check("late ack idle", grant, 2'b00);

        // starvation limit, driven through repeated aborts with both masters requesting
        tick;
        m0.cyc = 1'b1; m0.stb = 1'b1;
        m1.cyc = 1'b1; m1.stb = 1'b1; m1.we = 1'b1;
        for (int r = 0; r < 9; r++) begin
            n = 0;
            @(negedge clk);
            while (grant == 2'b00 && n < 30) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("arb %0d", r), grant, exp_arb[r]);
            if (r < 8) begin
                n = 0;
                while (!timeout && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("abort %0d", r), timeout, 1'b1);
            end
        end

        // async reset in the middle of an m1 write, streak at its limit
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst s_cyc drop", s.cyc, 1'b0);
        check("rst s_stb drop", s.stb, 1'b0);
        check("rst grant drop", grant, 2'b00);
        check("rst m1_err", m1.err, 1'b0);
        tick;
        tick;
        #2 rst_n = 1'b1;
        n = 0;
        @(negedge clk);
        while (grant == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("post rst arb", grant, 2'b10);
        m0.cyc = 1'b0; m0.stb = 1'b0; m1.cyc = 1'b0; m1.stb = 1'b0; m1.we = 1'b0;
        tick;
        tick;

        // terminations with no owner are ignored
        s.ack = 1'b1; s.err = 1'b1;
        @(negedge clk);
        check("idle grant", grant, 2'b00);
        check("idle m0_ack", m0.ack, 1'b0);
        check("idle m1_err", m1.err, 1'b0);
        tick;
        s.ack = 1'b0; s.err = 1'b0;
        m0.cyc = 1'b1;
        tick;
        tick;

        // ack and err together pass straight through to the owner
        q0.push_back(32'h0F0F_0F0F);
        s.ack = 1'b1; s.err = 1'b1; s.dat_r = 32'h0F0F_0F0F;
        @(negedge clk);
        check("both m0_err", m0.err, 1'b1);
        check("both m1_err", m1.err, 1'b0);
        tick;
        s.ack = 1'b0; s.err = 1'b0; m0.cyc = 1'b0;
        tick;
        tick;
        check("q0 drained", q0.size(), 0);
        check("q1 drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
